// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the two-client SDRAM arbiter.
// Latency: none (types only).
// Backpressure: none (types only).
package sdram_arb_pkg;

    localparam int ADDR_W = 27;
    localparam int DATA_W = 16;
    localparam int WTBT_W = 2;

    // Arbiter sequencing: grant in IDLE, hold strobe in ISSUE, await data in WAIT, ack in DONE
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        CL_A = 1'b0,
        CL_B = 1'b1
    } client_t;

    // Winner selection: a lone requester always wins; a tie goes to A in fixed
    // priority, or to whichever client was not served last in round-robin.
    function automatic client_t pick_client(input logic    rr,
                                            input logic    a_req,
                                            input logic    b_req,
                                            input client_t last);
        client_t win;
        if (a_req && b_req)
            win = (rr && (last == CL_A)) ? CL_B : CL_A;
        else if (a_req)
            win = CL_A;
        else
            win = CL_B;
        return win;
    endfunction

endpackage

// File: rtl/sdram_arb.sv
// Two-client arbiter in front of an edge-triggered SDRAM controller.
// Latency: 4 cycles req->ack best case, otherwise follows mem_ready timing.
// Backpressure: clients hold req until ack; nothing issues while mem_ready=0.
module sdram_arb
    import sdram_arb_pkg::*;
#(
    parameter bit RR = 1'b1
) (
    input  logic              clk,
    input  logic              init_n,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_din,
    input  logic [WTBT_W-1:0] a_wtbt,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_dout,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_din,
    input  logic [WTBT_W-1:0] b_wtbt,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_dout,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic [WTBT_W-1:0] mem_wtbt,
    output logic              mem_we,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_ready,

    output logic              busy
);

    state_t  state;
    client_t last_grant;
    client_t gnt;
    logic    gnt_wr;

    client_t           win;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_din;
    logic [WTBT_W-1:0] sel_wtbt;

    // Candidate winner and its request fields, only consumed at grant time
    assign win      = pick_client(RR, a_req, b_req, last_grant);
    assign sel_we   = (win == CL_A) ? a_we   : b_we;
    assign sel_addr = (win == CL_A) ? a_addr : b_addr;
    assign sel_din  = (win == CL_A) ? a_din  : b_din;
    assign sel_wtbt = (win == CL_A) ? a_wtbt : b_wtbt;

    // Arbitration FSM with all outputs registered. mem_addr/din/wtbt are only
    // loaded at grant, so they stay stable through ISSUE and WAIT while the
    // controller samples them late. DONE never grants, which both gives the
    // client a cycle to drop req and keeps each strobe low for >= 2 cycles.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state      <= ST_IDLE;
            last_grant <= CL_B;
            gnt        <= CL_A;
            gnt_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            mem_wtbt   <= '0;
            mem_we     <= 1'b0;
            mem_rd     <= 1'b0;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            a_dout     <= '0;
            b_dout     <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_ready && (a_req || b_req)) begin
                        gnt      <= win;
                        gnt_wr   <= sel_we;
                        mem_addr <= sel_addr;
                        mem_din  <= sel_din;
                        mem_wtbt <= sel_wtbt;
                        mem_we   <= sel_we;
                        mem_rd   <= ~sel_we;
                        busy     <= 1'b1;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Controller drops ready once it has taken the request
                    if (!mem_ready) begin
                        mem_we <= 1'b0;
                        mem_rd <= 1'b0;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_ready) begin
                        if (gnt == CL_A) begin
                            a_ack <= 1'b1;
                            if (!gnt_wr)
                                a_dout <= mem_dout;
                        end else begin
                            b_ack <= 1'b1;
                            if (!gnt_wr)
                                b_dout <= mem_dout;
                        end
                        last_grant <= gnt;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    a_ack <= 1'b0;
                    b_ack <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arb.sv
// Directed bench for sdram_arb: round-robin instance plus a fixed-priority instance.
// Each instance has its own registered controller model that drops ready after a strobe edge.
// Expected values are hand-derived constants in the stimulus sequence.
module tb_sdram_arb;
    import sdram_arb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              init_n;
    logic              a_req, b_req, a_we, b_we;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_din, b_din;
    logic [WTBT_W-1:0] a_wtbt, b_wtbt;

    // Round-robin instance
    logic              a_ack, b_ack, mem_we, mem_rd, busy, mem_ready;
    logic [DATA_W-1:0] a_dout, b_dout, mem_din, mem_dout;
    logic [ADDR_W-1:0] mem_addr;
    logic [WTBT_W-1:0] mem_wtbt;

    // Fixed-priority instance
    logic              a_ack_f, b_ack_f, mem_we_f, mem_rd_f, busy_f, mem_ready_f;
    logic [DATA_W-1:0] a_dout_f, b_dout_f, mem_din_f, mem_dout_f;
    logic [ADDR_W-1:0] mem_addr_f;
    logic [WTBT_W-1:0] mem_wtbt_f;

    sdram_arb #(.RR(1'b1)) dut (
        .clk(clk), .init_n(init_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_wtbt(a_wtbt),
        .a_ack(a_ack), .a_dout(a_dout),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_wtbt(b_wtbt),
        .b_ack(b_ack), .b_dout(b_dout),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wtbt(mem_wtbt),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_dout(mem_dout), .mem_ready(mem_ready),
        .busy(busy)
    );

    sdram_arb #(.RR(1'b0)) dut_fp (
        .clk(clk), .init_n(init_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_wtbt(a_wtbt),
        .a_ack(a_ack_f), .a_dout(a_dout_f),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_wtbt(b_wtbt),
        .b_ack(b_ack_f), .b_dout(b_dout_f),
        .mem_addr(mem_addr_f), .mem_din(mem_din_f), .mem_wtbt(mem_wtbt_f),
        .mem_we(mem_we_f), .mem_rd(mem_rd_f), .mem_dout(mem_dout_f), .mem_ready(mem_ready_f),
        .busy(busy_f)
    );

    // Controller model knobs
    logic        stall = 1'b0;
    int          lo_len = 1;
    logic [15:0] rd_data = 16'h0000;

    // Model for the round-robin instance, with strobe edge bookkeeping
    logic ready_r = 1'b1, strobe_q = 1'b0;
    int   lo_cnt = 0, cyc = 0, rises = 0, last_fall = 0, min_low = 1000, overlap = 0;
    int   a_ack_cnt = 0, a_ack_cnt_f = 0, b_ack_cnt_f = 0;
    assign mem_ready = ready_r & ~stall;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        strobe_q <= mem_rd | mem_we;
        if ((mem_rd | mem_we) && !strobe_q) begin
            ready_r <= 1'b0;
            lo_cnt  <= lo_len - 1;
            rises   <= rises + 1;
            if (rises > 0 && (cyc - last_fall) < min_low)
                min_low <= cyc - last_fall;
        end else if (!ready_r) begin
            if (lo_cnt == 0) begin
                ready_r  <= 1'b1;
                mem_dout <= rd_data;
            end else begin
                lo_cnt <= lo_cnt - 1;
            end
        end
        if (!(mem_rd | mem_we) && strobe_q)
            last_fall <= cyc;
        if (mem_rd && mem_we)
            overlap <= overlap + 1;
        if (a_ack)
            a_ack_cnt <= a_ack_cnt + 1;
        if (a_ack_f)
            a_ack_cnt_f <= a_ack_cnt_f + 1;
        if (b_ack_f)
            b_ack_cnt_f <= b_ack_cnt_f + 1;
    end

    // Same model for the fixed-priority instance
    logic ready_f_r = 1'b1, strobe_f_q = 1'b0;
    int   lo_cnt_f = 0;
    assign mem_ready_f = ready_f_r & ~stall;

    always @(posedge clk) begin
        strobe_f_q <= mem_rd_f | mem_we_f;
        if ((mem_rd_f | mem_we_f) && !strobe_f_q) begin
            ready_f_r <= 1'b0;
            lo_cnt_f  <= lo_len - 1;
        end else if (!ready_f_r) begin
            if (lo_cnt_f == 0) begin
                ready_f_r  <= 1'b1;
                mem_dout_f <= rd_data;
            end else begin
                lo_cnt_f <= lo_cnt_f - 1;
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input string tag, input bit on_b);
        int n;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!(on_b ? b_ack : a_ack) && n < 40);
        chk(tag, {31'd0, (on_b ? b_ack : a_ack)}, 32'd1);
    endtask

    task automatic settle(input string tag);
        int n;
        n = 0;
        while ((busy || busy_f || !ready_r || !ready_f_r) && n < 60) begin
            step(1);
            n++;
        end
        step(1);
        chk(tag, {30'd0, busy, busy_f}, 32'd0);
    endtask

    task automatic serve_next(input string tag, output bit who);
        int n;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!(a_ack || b_ack) && n < 40);
        chk(tag, {31'd0, (a_ack | b_ack)}, 32'd1);
        who = b_ack;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   who;
        int   sc, r0, acnt0, fa0, fb0;
        logic exp_who [4];
        exp_who[0] = 1'b0; exp_who[1] = 1'b1; exp_who[2] = 1'b0; exp_who[3] = 1'b1;

        init_n = 1'b0;
        a_req = 0; b_req = 0; a_we = 0; b_we = 0;
        a_addr = '0; b_addr = '0; a_din = '0; b_din = '0; a_wtbt = '0; b_wtbt = '0;
        step(2);

        // Reset state
        chk("rst_ctl",  {27'd0, mem_we, mem_rd, busy, a_ack, b_ack}, 32'd0);
        chk("rst_addr", {5'd0, mem_addr}, 32'd0);
        chk("rst_dout", {a_dout, b_dout}, 32'd0);
        chk("rst_din",  {14'd0, mem_wtbt, mem_din}, 32'd0);
        init_n = 1'b1;
        step(2);

        // Single read of A: strobe +1, ack +4, data BEEF
        a_we = 1'b0; a_addr = 27'h0000100; rd_data = 16'hBEEF; a_req = 1'b1;
        step(1);
        chk("rd_strobe_t1", {30'd0, mem_rd, mem_we}, 32'b10);
        chk("rd_addr_t1",   {5'd0, mem_addr}, 32'h100);
        chk("rd_busy_t1",   {31'd0, busy}, 32'd1);
        step(1);
        chk("rd_noack_t2",  {31'd0, a_ack}, 32'd0);
        step(1);
        chk("rd_noack_t3",  {30'd0, a_ack, mem_rd}, 32'd0);
        chk("rd_addr_t3",   {5'd0, mem_addr}, 32'h100);
        step(1);
        chk("rd_ack_t4",    {30'd0, a_ack, b_ack}, 32'b10);
        chk("rd_dout",      {16'd0, a_dout}, 32'hBEEF);
        a_req = 1'b0;
        step(1);
        chk("rd_ack_pulse", {30'd0, a_ack, busy}, 32'd0);
        settle("settle_rd");

        // Write from B: fields captured at grant, later changes ignored
        b_we = 1'b1; b_addr = 27'h0002000; b_din = 16'h1234; b_wtbt = 2'b10; b_req = 1'b1;
        step(1);
        chk("wr_strobe", {30'd0, mem_we, mem_rd}, 32'b10);
        chk("wr_din",    {16'd0, mem_din}, 32'h1234);
        chk("wr_wtbt",   {30'd0, mem_wtbt}, 32'b10);
        b_din = 16'hFFFF; b_wtbt = 2'b01; b_addr = 27'h0;
        wait_ack("wr_ack", 1'b1);
        chk("wr_din_hold",  {14'd0, mem_wtbt, mem_din}, {14'd0, 2'b10, 16'h1234});
        chk("wr_addr_hold", {5'd0, mem_addr}, 32'h2000);
        chk("wr_bdout",     {b_dout, a_dout}, {16'h0000, 16'hBEEF});
        b_req = 1'b0;
        settle("settle_wr");

        // Simultaneous writes held: RR alternates A,B,A,B; fixed priority serves only A
        a_we = 1'b1; b_we = 1'b1; a_addr = 27'h10; b_addr = 27'h20;
        a_din = 16'hAAAA; b_din = 16'hBBBB;
        fa0 = a_ack_cnt_f; fb0 = b_ack_cnt_f;
        a_req = 1'b1; b_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            serve_next($sformatf("tie_seen_%0d", i), who);
            chk($sformatf("rr_order_%0d", i), {31'd0, who}, {31'd0, exp_who[i]});
        end
        a_req = 1'b0; b_req = 1'b0;
        settle("settle_tie");
        chk("fp_b_never", b_ack_cnt_f - fb0, 32'd0);
        chk("fp_a_served", {31'd0, ((a_ack_cnt_f - fa0) >= 3)}, 32'd1);

        // Controller not ready: nothing issues until ready returns
        stall = 1'b1; a_we = 1'b0; a_addr = 27'h300; a_req = 1'b1;
        sc = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (mem_rd || mem_we) sc++;
        end
        chk("stall_no_strobe", sc, 32'd0);
        stall = 1'b0;
        step(1);
        chk("strobe_after_ready", {31'd0, mem_rd}, 32'd1);
        wait_ack("stall_ack", 1'b0);
        a_req = 1'b0;
        settle("settle_stall");

        // Back-to-back reads, same address, req held through the first ack
        r0 = rises;
        a_addr = 27'h400; rd_data = 16'h1111; a_req = 1'b1;
        wait_ack("b2b_ack1", 1'b0);
        chk("b2b_dout1", {16'd0, a_dout}, 32'h1111);
        rd_data = 16'h2222;
        wait_ack("b2b_ack2", 1'b0);
        chk("b2b_dout2", {16'd0, a_dout}, 32'h2222);
        a_req = 1'b0;
        settle("settle_b2b");
        chk("b2b_two_rises", rises - r0, 32'd2);

        // Reset asserted while waiting on the controller
        lo_len = 4; rd_data = 16'h7777; a_addr = 27'h500; a_req = 1'b1;
        step(1);
        sc = 0;
        while (mem_rd && sc < 20) begin
            step(1);
            sc++;
        end
        chk("reached_wait", {30'd0, busy, mem_rd}, 32'b10);
        step(1);
        acnt0 = a_ack_cnt;
        init_n = 1'b0;
        #1;
        chk("rst_mid_ctl",  {27'd0, mem_we, mem_rd, busy, a_ack, b_ack}, 32'd0);
        chk("rst_mid_addr", {5'd0, mem_addr}, 32'd0);
        chk("rst_mid_dout", {a_dout, b_dout}, 32'd0);
        a_req = 1'b0;
        step(3);
        init_n = 1'b1;
        step(10);
        chk("rst_no_ack", a_ack_cnt - acnt0, 32'd0);
        lo_len = 1; rd_data = 16'h5A5A; a_req = 1'b1;
        wait_ack("post_rst_ack", 1'b0);
        chk("post_rst_dout", {16'd0, a_dout}, 32'h5A5A);
        a_req = 1'b0;
        settle("settle_post_rst");

        // Whole-run strobe properties
        chk("no_we_rd_overlap", overlap, 32'd0);
        chk("strobe_low_ge2", {31'd0, (min_low >= 2)}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
